key_debounce_array: RTL and testbench

Multi-channel push-button conditioner for active-low mechanical keys. Each of `KEY_NUM` inputs is synchronised, debounced by a consecutive-sample counter, and reported as a stable level plus single-cycle press and release events, with optional long-press detection. It sits between the board key pins and application logic such as mode selects and counters, and it generalises the single-key filter to N independent channels with edge events.

---
 rtl/key_debounce_array.sv | 151 +++++++++++++++
 tb/tb_key_debounce_array.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// KEY_NUM-channel active-low key debouncer with level, press and release outputs.
// Define KEY_LONG_PRESS_EN to build the long-press counters and key_long pulses.
module key_debounce_array #(
  parameter int KEY_NUM  = 4,
  parameter int CNT_MAX  = 1_000_000,
  parameter int LONG_MAX = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] ST_UP      = 2'd0;
  localparam logic [1:0] ST_DB_DOWN = 2'd1;
  localparam logic [1:0] ST_DOWN    = 2'd2;
  localparam logic [1:0] ST_DB_UP   = 2'd3;

`ifdef KEY_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_MAX + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);
  localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_MAX);
  localparam logic [LW-1:0] LONG_ONE  = LW'(1);
`endif

  if (KEY_NUM < 1 || KEY_NUM > 16 || CNT_MAX < 1 || LONG_MAX < 1) begin : g_bad_cfg
    $error("key_debounce_array: illegal parameter set");
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic [1:0]    sync;
    logic          smp;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic          level;
    logic          press;
    logic          rel;
    logic          rel_now;

    assign smp     = sync[1];
    assign rel_now = (st == ST_DB_UP) && smp && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync <= 2'b11;
      end else begin
        sync <= {sync[0], key[i]};
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st    <= ST_UP;
        cnt   <= '0;
        level <= 1'b1;
        press <= 1'b0;
        rel   <= 1'b0;
      end else begin
        press <= 1'b0;
        rel   <= 1'b0;
        unique case (1'b1)
          st == ST_UP: begin
            if (!smp) begin
              st  <= ST_DB_DOWN;
              cnt <= '0;
            end
          end
          st == ST_DB_DOWN: begin
            if (smp) begin
              st  <= ST_UP;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              st    <= ST_DOWN;
              cnt   <= '0;
              level <= 1'b0;
              press <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          st == ST_DOWN: begin
            if (smp) begin
              st  <= ST_DB_UP;
              cnt <= '0;
            end
          end
          st == ST_DB_UP: begin
            if (!smp) begin
              st  <= ST_DOWN;
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              st    <= ST_UP;
              cnt   <= '0;
              level <= 1'b1;
              rel   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            st  <= ST_UP;
            cnt <= '0;
          end
        endcase
      end
    end

    assign key_state[i]   = level;
    assign key_press[i]   = press;
    assign key_release[i] = rel;

`ifdef KEY_LONG_PRESS_EN
    logic [LW-1:0] lcnt;
    logic          lpulse;

    // Hold time spans DB_UP bounces; only an accepted release clears it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lcnt   <= '0;
        lpulse <= 1'b0;
      end else begin
        lpulse <= 1'b0;
        if (rel_now) begin
          lcnt <= '0;
        end else if (st == ST_DOWN || st == ST_DB_UP) begin
          if (lcnt != LONG_SAT) begin
            lcnt <= lcnt + LONG_ONE;
          end
          if (lcnt == LONG_LAST) begin
            lpulse <= 1'b1;
          end
        end else begin
          lcnt <= '0;
        end
      end
    end

    assign key_long[i] = lpulse;
`else
    assign key_long[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench for key_debounce_array: stimulus queues expected events,
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_key_debounce_array;

  localparam int KN   = 4;
  localparam int CMAX = 1000;
  localparam int LMAX = 5000;
  localparam int LAT  = CMAX + 3;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [KN-1:0] key = '1;
  logic [KN-1:0] key_state;
  logic [KN-1:0] key_press;
  logic [KN-1:0] key_release;
  logic [KN-1:0] key_long;

  int  cyc = 0;
  int  compared = 0;
  int  mismatched = 0;
  ev_t q[$];

  key_debounce_array #(
    .KEY_NUM (KN),
    .CNT_MAX (CMAX),
    .LONG_MAX(LMAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key        (key),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t  e;
    logic hit;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < KN; c++) begin
        hit = (k == K_PRESS) ? key_press[c] :
              (k == K_REL)   ? key_release[c] : key_long[c];
        if (hit) begin
          compared++;
          if (q.size() == 0) begin
            mismatched++;
            $display("FAIL event: unexpected kind %0d ch %0d at cycle %0d, none required",
                     k, c, cyc);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.ch != c) begin
              mismatched++;
              $display("FAIL event: got kind %0d ch %0d cycle %0d, required kind %0d ch %0d cycle %0d",
                       k, c, cyc, e.kind, e.ch, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic expect_ev(input int at, input int kind, input int ch);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.ch   = ch;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    int p0;
    int p1;
    int c0;

    // reset hold
    wait_cyc(50);
    check("reset_state", 16'(key_state), 16'hf);
    check("reset_pulses", 16'({key_press, key_release, key_long}), 16'h0);
    rst = 1'b1;
    wait_cyc(2000);
    check("idle_state", 16'(key_state), 16'hf);

    // bounce rejection on channel 0, then settle low
    for (int i = 0; i < 100; i++) begin
      key[0] = ~key[0];
      wait_cyc(500);
    end
    check("bounce_state", 16'(key_state), 16'hf);
    key[0] = 1'b0;
    p0 = cyc + LAT;
    expect_ev(p0, K_PRESS, 0);
`ifdef KEY_LONG_PRESS_EN
    expect_ev(p0 + LMAX, K_LONG, 0);
`endif
    wait_cyc(1100);
    check("press0_state", 16'(key_state), 16'he);

    // release with bounce
    for (int i = 0; i < 20; i++) begin
      key[0] = ~key[0];
      wait_cyc(500);
    end
    check("rel_bounce_state", 16'(key_state), 16'he);
    key[0] = 1'b1;
    expect_ev(cyc + LAT, K_REL, 0);
    wait_cyc(1100);
    check("release0_state", 16'(key_state), 16'hf);

    // long press on channel 1
    key[1] = 1'b0;
    p1 = cyc + LAT;
    expect_ev(p1, K_PRESS, 1);
`ifdef KEY_LONG_PRESS_EN
    expect_ev(p1 + LMAX, K_LONG, 1);
`endif
    wait_cyc(8000);
    check("long_hold_state", 16'(key_state), 16'hd);
    key[1] = 1'b1;
    expect_ev(cyc + LAT, K_REL, 1);
    wait_cyc(1100);
    check("long_rel_state", 16'(key_state), 16'hf);

    // simultaneous press and release on channels 2 and 3
    key[3:2] = 2'b00;
    expect_ev(cyc + LAT, K_PRESS, 2);
    expect_ev(cyc + LAT, K_PRESS, 3);
    wait_cyc(1100);
    check("dual_state", 16'(key_state), 16'h3);
    key[3:2] = 2'b11;
    expect_ev(cyc + LAT, K_REL, 2);
    expect_ev(cyc + LAT, K_REL, 3);
    wait_cyc(1100);
    check("dual_rel_state", 16'(key_state), 16'hf);

    // reset in the middle of a debounce, then a fresh press
    key[0] = 1'b0;
    wait_cyc(600);
    rst = 1'b0;
    #1;
    check("midrst_state", 16'(key_state), 16'hf);
    check("midrst_pulses", 16'({key_press, key_release, key_long}), 16'h0);
    wait_cyc(10);
    rst = 1'b1;
    c0 = cyc;
    expect_ev(c0 + LAT, K_PRESS, 0);
    wait_cyc(1100);
    check("post_rst_state", 16'(key_state), 16'he);
    key[0] = 1'b1;
    expect_ev(cyc + LAT, K_REL, 0);
    wait_cyc(1100);
    check("final_state", 16'(key_state), 16'hf);
    check("long_never", 16'(key_long), 16'h0);

    check("events_left", 16'(q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
